proc_test_sequencer: RTL and testbench

Synthesizable, parametrised self-check sequencer for the single-cycle processor. It holds the processor in reset, releases it from a programmed start PC, and watches `currentpc` and `MemtoRegOut` against a table of NUM_TESTS checkpoints, each a PC threshold plus an expected result. It runs a cycle watchdog and reports pass count, a per-checkpoint fail mask and an overall verdict. It sits beside `singlecycle` in FPGA bring-up builds, so no simulator is needed to run the program regressions.

---
 rtl/proc_test_pkg.sv | 27 ++
 rtl/proc_test_sequencer_cp_table.sv | 27 ++
 rtl/proc_test_sequencer.sv | 151 +++++++++++++++
 tb/tb_proc_test_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_test_pkg.sv
// Shared types for the processor self-check sequencer: FSM states, checkpoint record, clog2.
package proc_test_pkg;

  localparam int unsigned CP_PC_MAX_W   = 64;
  localparam int unsigned CP_DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Checkpoint fields are sized for the widest supported PC/data; narrower builds zero-extend.
  typedef struct packed {
    logic [CP_PC_MAX_W-1:0]   pc;
    logic [CP_DATA_MAX_W-1:0] exp;
  } cp_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/proc_test_sequencer_cp_table.sv
// Checkpoint register file: one write port, one asynchronous read port. Not reset.
module cp_table
  import proc_test_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  cp_t              wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output cp_t              rd_c
);

  cp_t entries [NUM_TESTS];

  // Out-of-range writes are dropped so non-power-of-two tables stay consistent.
  always_ff @(posedge clk) begin
    if (we && (32'(wr_idx) < NUM_TESTS)) begin
      entries[wr_idx] <= wr_data;
    end
  end

  assign rd_c = (32'(rd_idx) < NUM_TESTS) ? entries[rd_idx] : '0;

endmodule

// File: rtl/proc_test_sequencer.sv
// Holds the processor in reset, releases it from a start PC and scores result checkpoints
// against a programmed table under a cycle watchdog.
module proc_test_sequencer
  import proc_test_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned PC_W         = 64,
  parameter int unsigned NUM_TESTS    = 2,
  parameter int unsigned WDOG_W       = 16,
  parameter int unsigned WDOG_LIMIT   = 255,
  parameter int unsigned RESET_CYCLES = 2,
  localparam int unsigned IDX_W = (clog2(NUM_TESTS) == 0) ? 1 : clog2(NUM_TESTS),
  localparam int unsigned CNT_W = clog2(NUM_TESTS + 1)
) (
  input  logic                 CLK,
  input  logic                 resetl,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [PC_W-1:0]      cfg_pc,
  input  logic [DATA_W-1:0]    cfg_exp,
  input  logic [PC_W-1:0]      currentpc,
  input  logic [DATA_W-1:0]    mem_to_reg,
  output logic                 proc_resetl,
  output logic [PC_W-1:0]      proc_startpc,
  output logic                 busy,
  output logic                 done,
  output logic                 all_passed,
  output logic [CNT_W-1:0]     pass_count,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic                 wdog_expired
);

  localparam int unsigned RC_W = clog2(RESET_CYCLES + 1);
  localparam int unsigned FL_W = IDX_W + 1;

  seq_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [WDOG_W-1:0] wdog;
  logic [RC_W-1:0]  rst_cnt;

  cp_t cp_wr_c;
  cp_t cp_rd_c;
  logic cfg_wr_c;

  logic                 cp_hit_c;
  logic                 cp_ok_c;
  logic                 cp_last_c;
  logic                 wdog_hit_c;
  logic                 timeout_c;
  logic [FL_W-1:0]      first_left_c;
  logic [CNT_W-1:0]     pass_next_c;
  logic [NUM_TESTS-1:0] fail_next_c;

  assign cfg_wr_c = cfg_we && ((state == IDLE) || (state == DONE));

  always_comb begin
    cp_wr_c     = '0;
    cp_wr_c.pc  = CP_PC_MAX_W'(cfg_pc);
    cp_wr_c.exp = CP_DATA_MAX_W'(cfg_exp);
  end

  cp_table #(
    .NUM_TESTS (NUM_TESTS),
    .IDX_W     (IDX_W)
  ) u_cp_table (
    .clk     (CLK),
    .we      (cfg_wr_c),
    .wr_idx  (cfg_idx),
    .wr_data (cp_wr_c),
    .rd_idx  (idx),
    .rd_c    (cp_rd_c)
  );

  // Checkpoint evaluation first, then the timeout covers whatever indices remain.
  always_comb begin
    cp_hit_c     = currentpc >= PC_W'(cp_rd_c.pc);
    cp_ok_c      = mem_to_reg == DATA_W'(cp_rd_c.exp);
    cp_last_c    = idx == IDX_W'(NUM_TESTS - 1);
    wdog_hit_c   = WDOG_W'(wdog + 1'b1) == WDOG_W'(WDOG_LIMIT);
    timeout_c    = wdog_hit_c && !(cp_hit_c && cp_last_c);
    first_left_c = cp_hit_c ? FL_W'({1'b0, idx} + 1'b1) : FL_W'({1'b0, idx});
    pass_next_c  = pass_count + CNT_W'(cp_hit_c && cp_ok_c);
    fail_next_c  = fail_mask;
    if (cp_hit_c && !cp_ok_c) fail_next_c[idx] = 1'b1;
    if (timeout_c) begin
      for (int i = 0; i < int'(NUM_TESTS); i++) begin
        if (FL_W'(i) >= first_left_c) fail_next_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state        <= IDLE;
      proc_resetl  <= 1'b0;
      proc_startpc <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      all_passed   <= 1'b0;
      wdog_expired <= 1'b0;
      pass_count   <= '0;
      fail_mask    <= '0;
      idx          <= '0;
      wdog         <= '0;
      rst_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RST;
            proc_resetl  <= 1'b0;
            proc_startpc <= start_pc;
            busy         <= 1'b1;
            done         <= 1'b0;
            all_passed   <= 1'b0;
            wdog_expired <= 1'b0;
            pass_count   <= '0;
            fail_mask    <= '0;
            idx          <= '0;
            wdog         <= '0;
            rst_cnt      <= '0;
          end
        end
        RST: begin
          rst_cnt <= RC_W'(rst_cnt + 1'b1);
          if (RC_W'(rst_cnt + 1'b1) == RC_W'(RESET_CYCLES)) begin
            state       <= RUN;
            proc_resetl <= 1'b1;
          end
        end
        RUN: begin
          wdog       <= WDOG_W'(wdog + 1'b1);
          pass_count <= pass_next_c;
          fail_mask  <= fail_next_c;
          if (cp_hit_c && !cp_last_c) idx <= IDX_W'(idx + 1'b1);
          if (timeout_c) wdog_expired <= 1'b1;
          if ((cp_hit_c && cp_last_c) || timeout_c) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            all_passed <= !timeout_c && (pass_next_c == CNT_W'(NUM_TESTS));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Directed bench for proc_test_sequencer: table-driven checkpoint runs plus watchdog/reset sequences.
module tb_proc_test_sequencer;

  localparam logic [63:0] C1 = 64'h1234_5678_9ABC_DEF0;

  logic        CLK;
  logic        resetl;
  logic        start;
  logic [63:0] start_pc;
  logic        cfg_we;
  logic [0:0]  cfg_idx;
  logic [63:0] cfg_pc;
  logic [63:0] cfg_exp;
  logic [63:0] currentpc;
  logic [63:0] mem_to_reg;
  logic        proc_resetl;
  logic [63:0] proc_startpc;
  logic        busy;
  logic        done;
  logic        all_passed;
  logic [1:0]  pass_count;
  logic [1:0]  fail_mask;
  logic        wdog_expired;

  int total = 0;
  int bad   = 0;

  proc_test_sequencer #(
    .DATA_W       (64),
    .PC_W         (64),
    .NUM_TESTS    (2),
    .WDOG_W       (16),
    .WDOG_LIMIT   (255),
    .RESET_CYCLES (2)
  ) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .start        (start),
    .start_pc     (start_pc),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_pc       (cfg_pc),
    .cfg_exp      (cfg_exp),
    .currentpc    (currentpc),
    .mem_to_reg   (mem_to_reg),
    .proc_resetl  (proc_resetl),
    .proc_startpc (proc_startpc),
    .busy         (busy),
    .done         (done),
    .all_passed   (all_passed),
    .pass_count   (pass_count),
    .fail_mask    (fail_mask),
    .wdog_expired (wdog_expired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          restart;
    logic [63:0] pc;
    logic [63:0] data;
    logic [1:0]  pass;
    logic [1:0]  fail;
    bit          dn;
    bit          all;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic check(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [0:0] i, input logic [63:0] pc, input logic [63:0] exp);
    cfg_we = 1'b1; cfg_idx = i; cfg_pc = pc; cfg_exp = exp;
    step();
    cfg_we = 1'b0;
  endtask

  // Start pulse plus the two reset cycles; returns right after RUN entry.
  task automatic run_start(input logic [63:0] pc);
    start = 1'b1; start_pc = pc; currentpc = '0; mem_to_reg = '0;
    step();
    start = 1'b0;
    step();
    step();
    check("run_entry_resetl", 0, 64'(proc_resetl), 64'd1);
  endtask

  task automatic run_cycles(input int n, input logic [63:0] pc, input logic [63:0] data);
    currentpc = pc; mem_to_reg = data;
    repeat (n) step();
  endtask

  task automatic check_result(input int tag, input logic [1:0] p, input logic [1:0] f,
                              input logic d, input logic a, input logic w);
    check("pass_count", tag, 64'(pass_count), 64'(p));
    check("fail_mask", tag, 64'(fail_mask), 64'(f));
    check("done", tag, 64'(done), 64'(d));
    check("all_passed", tag, 64'(all_passed), 64'(a));
    check("wdog_expired", tag, 64'(wdog_expired), 64'(w));
  endtask

  initial begin
    vt[0]  = '{1'b1, 64'h00, 64'h0, 2'd0, 2'b00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 64'h2C, 64'hF, 2'd0, 2'b00, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 64'h30, 64'hF, 2'd1, 2'b00, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 64'h34, 64'hF, 2'd1, 2'b00, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 64'h50, C1,    2'd2, 2'b00, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 64'h54, 64'h0, 2'd2, 2'b00, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 64'h30, 64'hE, 2'd0, 2'b01, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 64'h50, C1,    2'd1, 2'b01, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 64'h30, 64'hF, 2'd1, 2'b00, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 64'h50, 64'h0, 2'd1, 2'b10, 1'b1, 1'b0};
    vt[10] = '{1'b1, 64'h60, 64'hF, 2'd1, 2'b00, 1'b0, 1'b0};
    vt[11] = '{1'b0, 64'h60, C1,    2'd2, 2'b00, 1'b1, 1'b1};
    vt[12] = '{1'b1, 64'h60, C1,    2'd0, 2'b01, 1'b0, 1'b0};
    vt[13] = '{1'b0, 64'h60, 64'hF, 2'd0, 2'b11, 1'b1, 1'b0};

    resetl = 1'b0; start = 1'b0; start_pc = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_pc = '0; cfg_exp = '0; currentpc = '0; mem_to_reg = '0;
    step();
    step();
    check("rst_proc_resetl", 0, 64'(proc_resetl), 64'd0);
    check("rst_proc_startpc", 0, proc_startpc, 64'd0);
    check("rst_busy", 0, 64'(busy), 64'd0);
    check_result(0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    resetl = 1'b1;
    step();

    cfg_write(1'b0, 64'h30, 64'hF);
    cfg_write(1'b1, 64'h50, C1);

    // Reset sequencing, then start and cfg writes while busy must be ignored.
    start = 1'b1; start_pc = 64'h10;
    step();
    start = 1'b0;
    check("seq_resetl_t0", 0, 64'(proc_resetl), 64'd0);
    check("seq_startpc", 0, proc_startpc, 64'h10);
    check("seq_busy", 0, 64'(busy), 64'd1);
    step();
    check("seq_resetl_t1", 0, 64'(proc_resetl), 64'd0);
    step();
    check("seq_resetl_t2", 0, 64'(proc_resetl), 64'd1);
    start = 1'b1; start_pc = 64'h99;
    step();
    start = 1'b0;
    check("ign_start_resetl", 0, 64'(proc_resetl), 64'd1);
    check("ign_start_startpc", 0, proc_startpc, 64'h10);
    cfg_write(1'b0, 64'h0, 64'h0);
    run_cycles(1, 64'h0, 64'h0);
    check("ign_cfg_pass", 0, 64'(pass_count), 64'd0);
    run_cycles(1, 64'h30, 64'hF);
    run_cycles(1, 64'h50, C1);
    check_result(1, 2'd2, 2'b00, 1'b1, 1'b1, 1'b0);
    check("done_busy", 0, 64'(busy), 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].restart) run_start(64'h0);
      currentpc = vt[i].pc; mem_to_reg = vt[i].data;
      step();
      check("vec_pass", i, 64'(pass_count), 64'(vt[i].pass));
      check("vec_fail", i, 64'(fail_mask), 64'(vt[i].fail));
      check("vec_done", i, 64'(done), 64'(vt[i].dn));
      check("vec_all", i, 64'(all_passed), 64'(vt[i].all));
    end

    // Stuck PC: timeout exactly 255 cycles after RUN entry.
    run_start(64'h0);
    run_cycles(254, 64'h20, 64'h0);
    check("stuck_pre_wdog", 0, 64'(wdog_expired), 64'd0);
    check("stuck_pre_busy", 0, 64'(busy), 64'd1);
    run_cycles(1, 64'h20, 64'h0);
    check_result(2, 2'd0, 2'b11, 1'b1, 1'b0, 1'b1);

    // Last checkpoint lands on the watchdog edge: no timeout.
    run_start(64'h0);
    run_cycles(1, 64'h30, 64'hF);
    run_cycles(253, 64'h40, 64'h0);
    check("same_edge_pre_done", 0, 64'(done), 64'd0);
    run_cycles(1, 64'h50, C1);
    check_result(3, 2'd2, 2'b00, 1'b1, 1'b1, 1'b0);

    // First checkpoint lands on the watchdog edge: evaluated, remainder times out.
    run_start(64'h0);
    run_cycles(254, 64'h20, 64'h0);
    run_cycles(1, 64'h30, 64'hF);
    check_result(4, 2'd1, 2'b10, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-RUN.
    run_start(64'h40);
    run_cycles(1, 64'h30, 64'hF);
    check("pre_areset_pass", 0, 64'(pass_count), 64'd1);
    #3;
    resetl = 1'b0;
    #1;
    check("areset_resetl", 0, 64'(proc_resetl), 64'd0);
    check("areset_startpc", 0, proc_startpc, 64'd0);
    check("areset_busy", 0, 64'(busy), 64'd0);
    check_result(5, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    resetl = 1'b1;
    step();
    cfg_write(1'b0, 64'h30, 64'hF);
    cfg_write(1'b1, 64'h50, C1);
    run_start(64'h10);
    check("rerun_startpc", 0, proc_startpc, 64'h10);
    run_cycles(1, 64'h30, 64'hF);
    run_cycles(1, 64'h50, C1);
    check_result(6, 2'd2, 2'b00, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
